// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a length-prefixed little-endian program from a byte link into IMEM,
// stalling the CPU on NOPs until the load completes, then hands the IMEM address port to the CPU.
module imem_boot_loader #(
   parameter int          DEPTH          = 1024,
   parameter int          TIMEOUT_CYCLES = 100000,
   parameter bit          BOOT_ON_RESET  = 1'b1,
   parameter logic [31:0] NOP_WORD       = 32'hE1A00000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   input  logic        load_start,
   input  logic [31:0] cpu_pc,
   output logic [31:0] cpu_instr,
   output logic        cpu_stall,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd,
   output logic        load_err,
   output logic [15:0] words_loaded
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, WRITE, RUN, ERROR} state_t;
   state_t st, nxt;
   logic [15:0]   len, len_full;
   logic [AW-1:0] word_idx;
   logic [1:0]    byte_idx;
   logic [31:0]   shift;
   logic [TW-1:0] timer;
   logic          xfer, tmo, last, too_big, run;
   assign run      = st == RUN;
   assign rx_ready = st == LEN_LO || st == LEN_HI || st == DATA;
   assign xfer     = rx_valid && rx_ready;
   assign len_full = {rx_data, len[7:0]};
   assign too_big  = {1'b0, len_full} > 17'(DEPTH);
   assign tmo      = timer == TW'(TIMEOUT_CYCLES - 1);
   assign last     = 16'(word_idx) == len - 16'd1;
   assign cpu_stall = !run;
   assign cpu_instr = run ? mem_rd : NOP_WORD;
   assign mem_addr  = run ? cpu_pc : 32'({word_idx, 2'b00});
   assign mem_we    = st == WRITE;
   assign mem_wd    = shift;
   always_comb begin
      nxt = st;
      case (st)
         LEN_LO:  nxt = xfer ? LEN_HI : LEN_LO;
         LEN_HI:  nxt = xfer ? (len_full == 16'd0 ? RUN : too_big ? ERROR : DATA) : tmo ? ERROR : LEN_HI;
         DATA:    nxt = xfer ? (byte_idx == 2'd3 ? WRITE : DATA) : tmo ? ERROR : DATA;
         WRITE:   nxt = last ? RUN : DATA;
         RUN:     nxt = load_start ? LEN_LO : RUN;
         ERROR:   nxt = load_start ? LEN_LO : ERROR;
         default: nxt = st;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st           <= BOOT_ON_RESET ? LEN_LO : RUN;
         len          <= '0;
         word_idx     <= '0;
         byte_idx     <= '0;
         shift        <= '0;
         timer        <= '0;
         load_err     <= 1'b0;
         words_loaded <= '0;
      end else begin
         st    <= nxt;
         // idle counter only runs while waiting for a byte mid-load
         timer <= (xfer || nxt != st) ? '0 : (st == LEN_HI || st == DATA) ? timer + TW'(1) : timer;
         case (st)
            LEN_LO: if (xfer) len[7:0] <= rx_data;
            LEN_HI: begin
               if (xfer) begin
                  len      <= len_full;
                  word_idx <= '0;
                  byte_idx <= '0;
                  if (too_big) load_err <= 1'b1;
                  else if (len_full != 16'd0) words_loaded <= '0;
               end else if (tmo) load_err <= 1'b1;
            end
            DATA: begin
               if (xfer) begin
                  shift[8*byte_idx +: 8] <= rx_data;
                  byte_idx               <= byte_idx + 2'd1;
               end else if (tmo) load_err <= 1'b1;
            end
            WRITE: begin
               word_idx     <= word_idx + AW'(1);
               words_loaded <= words_loaded == 16'(DEPTH) ? words_loaded : words_loaded + 16'd1;
            end
            RUN: if (load_start) begin
               load_err     <= 1'b0;
               words_loaded <= '0;
            end
            ERROR: if (load_start) load_err <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed vectors for imem_boot_loader against a behavioural IMEM and write log.
module tb_imem_boot_loader;
   logic        clk = 1'b0, reset_n = 1'b0, rx_valid = 1'b0, load_start = 1'b0;
   logic [7:0]  rx_data = '0;
   logic [31:0] cpu_pc = '0, mem_rd, cpu_instr, mem_addr, mem_wd;
   logic        rx_ready, cpu_stall, mem_we, load_err;
   logic [15:0] words_loaded;
   logic [31:0] imem [1024];
   logic [31:0] log_a [16], log_d [16];
   int          wr_cnt = 0, n_vec = 0, n_err = 0;

   imem_boot_loader #(.DEPTH(1024), .TIMEOUT_CYCLES(16), .BOOT_ON_RESET(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .load_start(load_start), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .cpu_stall(cpu_stall),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .load_err(load_err), .words_loaded(words_loaded));

   always #5 clk = ~clk;
   assign mem_rd = imem[mem_addr[11:2]];
   always @(posedge clk) if (mem_we) begin
      imem[mem_addr[11:2]] <= mem_wd;
      log_a[wr_cnt[3:0]]   <= mem_addr;
      log_d[wr_cnt[3:0]]   <= mem_wd;
      wr_cnt               <= wr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      while (!rx_ready && n < 50) begin
         tick();
         n++;
      end
      if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) imem[i] = '0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("rst_stall", 32'(cpu_stall), 32'd1);
      check("rst_ready", 32'(rx_ready), 32'd1);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_wd", mem_wd, 32'd0);
      check("rst_err", 32'(load_err), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      check("rst_nop", cpu_instr, 32'hE1A00000);
      // T1 boot of two words
      send(8'h02); send(8'h00);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      check("t1_we0", 32'(mem_we), 32'd1);
      check("t1_addr0", mem_addr, 32'h0);
      check("t1_wd0", mem_wd, 32'h12345678);
      check("t1_ready_wr", 32'(rx_ready), 32'd0);
      check("t1_nop", cpu_instr, 32'hE1A00000);
      send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
      check("t1_we1", 32'(mem_we), 32'd1);
      check("t1_addr1", mem_addr, 32'h4);
      check("t1_wd1", mem_wd, 32'hDEADBEEF);
      check("t1_stall_wr", 32'(cpu_stall), 32'd1);
      tick();
      check("t1_stall_run", 32'(cpu_stall), 32'd0);
      check("t1_we_run", 32'(mem_we), 32'd0);
      check("t1_words", 32'(words_loaded), 32'd2);
      check("t1_wr_cnt", wr_cnt, 2);
      check("t1_log_a1", log_a[1], 32'h4);
      check("t1_log_d0", log_d[0], 32'h12345678);
      // T5 handoff to CPU
      cpu_pc = 32'h4;
      #1;
      check("t5_addr", mem_addr, 32'h4);
      check("t5_instr4", cpu_instr, 32'hDEADBEEF);
      cpu_pc = 32'h0;
      #1;
      check("t5_instr0", cpu_instr, 32'h12345678);
      // T2 zero-length load
      pulse_start();
      check("t2_stall", 32'(cpu_stall), 32'd1);
      check("t2_words_clr", 32'(words_loaded), 32'd0);
      send(8'h00); send(8'h00);
      check("t2_run", 32'(cpu_stall), 32'd0);
      check("t2_err", 32'(load_err), 32'd0);
      check("t2_wr_cnt", wr_cnt, 2);
      // T3 oversize length 1025
      pulse_start();
      send(8'h01); send(8'h04);
      check("t3_err", 32'(load_err), 32'd1);
      check("t3_stall", 32'(cpu_stall), 32'd1);
      check("t3_ready", 32'(rx_ready), 32'd0);
      check("t3_wr_cnt", wr_cnt, 2);
      pulse_start();
      check("t3_err_clr", 32'(load_err), 32'd0);
      check("t3_ready_ll", 32'(rx_ready), 32'd1);
      // T4 timeout 16 cycles after the last byte
      send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
      repeat (15) tick();
      check("t4_err_early", 32'(load_err), 32'd0);
      tick();
      check("t4_err", 32'(load_err), 32'd1);
      check("t4_ready", 32'(rx_ready), 32'd0);
      check("t4_wr_cnt", wr_cnt, 2);
      // T6 reset mid-load, then reload
      pulse_start();
      send(8'h02); send(8'h00);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      tick();
      check("t6_words_pre", 32'(words_loaded), 32'd1);
      send(8'h05); send(8'h06); send(8'h07);
      reset_n = 1'b0;
      #2;
      check("t6_we", 32'(mem_we), 32'd0);
      check("t6_words", 32'(words_loaded), 32'd0);
      check("t6_ready", 32'(rx_ready), 32'd1);
      check("t6_stall", 32'(cpu_stall), 32'd1);
      tick();
      reset_n = 1'b1;
      send(8'h01); send(8'h00);
      send(8'h44); send(8'h33); send(8'h22); send(8'h11);
      tick();
      check("t6_run", 32'(cpu_stall), 32'd0);
      check("t6_words_re", 32'(words_loaded), 32'd1);
      check("t6_wr_cnt", wr_cnt, 4);
      check("t6_instr", cpu_instr, 32'h11223344);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
